dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of words (power of two).
REQ-003 The block SHALL have parameter RD_LAT, default 1, read latency in cycles (legal 1..4).
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-005 The block SHALL have parameter CLEAR_ON_RST, default 1, which zero-fills the array after reset when set.
REQ-006 The block SHALL have parameter FILENAME, default "", a hex image loaded at time zero when non-empty.
REQ-007 The block SHALL have port CLK, input, 1, the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port ADDR, input, 32, byte address.
REQ-010 The block SHALL have port DATA_IN, input, WORD_SIZE, write data.
REQ-011 The block SHALL have port BYTE_EN, input, WORD_SIZE/8, write lane strobes.
REQ-012 The block SHALL have port WR_EN, input, 1, write request.
REQ-013 The block SHALL have port RD_EN, input, 1, read request.
REQ-014 The block SHALL have port READY, output, 1, requests accepted while high.
REQ-015 The block SHALL have port DATA_OUT, output, WORD_SIZE, read data.
REQ-016 The block SHALL have port VALID, output, 1, one-cycle strobe qualifying DATA_OUT.
REQ-017 The block SHALL have port ERR, output, 1, one-cycle strobe flagging a rejected request.

Function
REQ-018 Request acceptance SHALL occur on a rising CLK edge with READY=1 and WR_EN or RD_EN high; requests while READY=0 SHALL be ignored without ERR.
REQ-019 The word index SHALL be (ADDR-BASE_ADDR)>>log2(WORD_SIZE/8), computed at 32 bits.
REQ-020 Misaligned ADDR (low byte-offset bits nonzero), index>=DEPTH, or ADDR<BASE_ADDR SHALL reject: no array write, ERR pulse RD_LAT cycles later, VALID=0 and DATA_OUT=0 in that slot.
REQ-021 WR_EN and RD_EN high together SHALL reject as in REQ-020.
REQ-022 An accepted write SHALL update only the byte lanes with BYTE_EN=1 at that edge; BYTE_EN=0 SHALL be a legal no-op write (no ERR).
REQ-023 An accepted read SHALL drive DATA_OUT and VALID=1 exactly RD_LAT cycles after the accepting edge, for one cycle.
REQ-024 Reads SHALL be fully pipelined: one request per cycle, responses in request order.
REQ-025 A read accepted the cycle after a write to the same word SHALL return the written data (no hazard window).
REQ-026 DATA_OUT SHALL hold its last valid value while VALID=0.
REQ-027 The FSM SHALL have states CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RST=1, else RUN.
REQ-028 CLEAR SHALL write zero to one word per cycle, indices 0..DEPTH-1, READY=0, then enter RUN on the cycle after index DEPTH-1; READY=1 only in RUN.
REQ-029 The clear counter SHALL be log2(DEPTH)+1 bits and SHALL not wrap.

Reset
REQ-030 Asserting RST at any time SHALL immediately force READY=0, VALID=0, ERR=0, DATA_OUT=0, clear counter=0, and flush all in-flight reads.
REQ-031 Array contents SHALL be unaffected by RST itself; only the CLEAR state modifies them.
REQ-032 Reset deassertion SHALL be synchronised internally with a two-flop release before leaving the reset state.

Structure
REQ-033 A shared package SHALL hold FSM state encoding (CLEAR, RUN), RD_LAT bounds and the byte-lane width constant.
REQ-034 The read-latency shift register (data, valid, err per stage) SHALL be a sub-module named dmem_rd_pipe.
REQ-035 An out-of-range RD_LAT SHALL fail elaboration.

Verification
REQ-036 Reset with CLEAR_ON_RST=1, DEPTH=16 -> READY rises exactly 16 cycles after synchronised release; read of index 5 returns 0.
REQ-037 Write 32'hDEADBEEF to BASE_ADDR+8 with BYTE_EN=4'b0101, after prior full write 32'h11223344 -> read returns 32'h11AD33EF, VALID at accept+RD_LAT.
REQ-038 RD_LAT=3, back-to-back reads of indices 0,1,2 -> three consecutive VALID cycles, correct order.
REQ-039 ADDR=BASE_ADDR+2, ADDR=BASE_ADDR+4*DEPTH, and WR_EN=RD_EN=1 -> ERR pulse each, VALID=0, target word unchanged.
REQ-040 Write then read same word on the next cycle -> new data returned.
REQ-041 RST asserted with two reads in flight -> no VALID appears; after reset READY follows REQ-028.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, read-latency
// bounds and the byte-lane width.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned BYTE_W     = 8;

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-response delay line: RD_LAT stages of {data, valid, err}; the last stage
// holds its data while no response is presented and zeroes it on a reject.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_err,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  output logic                 out_err,
  output logic [WORD_SIZE-1:0] out_data
);

  logic [RD_LAT-1:0]                valid_r;
  logic [RD_LAT-1:0]                err_r;
  logic [RD_LAT-1:0][WORD_SIZE-1:0] data_r;
  logic [RD_LAT-1:0]                src_valid;
  logic [RD_LAT-1:0]                src_err;
  logic [RD_LAT-1:0][WORD_SIZE-1:0] src_data;

  // Stage inputs: the request slot feeds stage 0, each later stage its predecessor.
  always_comb begin
    src_valid   = '0;
    src_err     = '0;
    src_data    = '0;
    src_valid[0] = in_valid;
    src_err[0]   = in_err;
    src_data[0]  = in_data;
    for (int k = 1; k < int'(RD_LAT); k++) begin
      src_valid[k] = valid_r[k-1];
      src_err[k]   = err_r[k-1];
      src_data[k]  = data_r[k-1];
    end
  end

  // Shift register; the final data stage only changes on a response slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      err_r   <= '0;
      data_r  <= '0;
    end else begin
      for (int k = 0; k < int'(RD_LAT); k++) begin
        valid_r[k] <= src_valid[k];
        err_r[k]   <= src_err[k];
        if (k == int'(RD_LAT) - 1) begin
          if (src_valid[k]) begin
            data_r[k] <= src_data[k];
          end else if (src_err[k]) begin
            data_r[k] <= '0;
          end
        end else begin
          data_r[k] <= src_data[k];
        end
      end
    end
  end

  assign out_valid = valid_r[RD_LAT-1];
  assign out_err   = err_r[RD_LAT-1];
  assign out_data  = data_r[RD_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with byte-lane writes, pipelined fixed-latency reads,
// request rejection with an error strobe, and an optional post-reset zero fill.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned RD_LAT       = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter bit          CLEAR_ON_RST = 1'b1,
  parameter string       FILENAME     = ""
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            ADDR,
  input  logic [WORD_SIZE-1:0]   DATA_IN,
  input  logic [WORD_SIZE/8-1:0] BYTE_EN,
  input  logic                   WR_EN,
  input  logic                   RD_EN,
  output logic                   READY,
  output logic [WORD_SIZE-1:0]   DATA_OUT,
  output logic                   VALID,
  output logic                   ERR
);

  localparam int unsigned BYTES     = WORD_SIZE / BYTE_W;
  localparam int unsigned LANE_BITS = $clog2(BYTES);
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam state_t ST_INIT = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("dmem_ctrl: RD_LAT out of range");
  end
  if ((WORD_SIZE % BYTE_W) != 0) begin : g_bad_word_size
    $error("dmem_ctrl: WORD_SIZE must be a multiple of 8");
  end

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [1:0]       sync_r;
  logic             released;
  state_t           state_r, state_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic             clr_we;
  logic             ready_r;

  // Two-flop release of the asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  assign released = sync_r[1];

  // FSM state, clear counter and registered READY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      ready_r <= (state_next == ST_RUN) && sync_r[0];
    end
  end

  // Next-state logic: one zero write per cycle once released, counter saturates.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    clr_we     = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        if (released) begin
          clr_we = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_CLEAR;
            cnt_next   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_next = ST_CLEAR;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  logic [31:0]          offset;
  logic [31:0]          idx_full;
  logic [IDX_W-1:0]     idx;
  logic                 bad;
  logic                 accept;
  logic                 wr_ok;
  logic                 rd_ok;
  logic [WORD_SIZE-1:0] rd_word;

  // Offset is computed at 32 bits, so addresses below BASE_ADDR are caught explicitly.
  assign offset   = ADDR - BASE_ADDR;
  assign idx_full = offset >> LANE_BITS;
  assign idx      = idx_full[IDX_W-1:0];
  assign bad      = ((offset & 32'(BYTES - 1)) != 32'd0) || (idx_full >= 32'(DEPTH)) ||
                    (ADDR < BASE_ADDR) || (WR_EN && RD_EN);
  assign accept   = ready_r && (WR_EN || RD_EN);
  assign wr_ok    = accept && WR_EN && !bad;
  assign rd_ok    = accept && RD_EN && !bad;
  assign rd_word  = rd_ok ? mem[idx] : '0;

  // Single write port shared by the zero fill and byte-lane user writes.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt_r[IDX_W-1:0]] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (BYTE_EN[i]) begin
          mem[idx][i*BYTE_W +: BYTE_W] <= DATA_IN[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  dmem_rd_pipe #(
    .WORD_SIZE(WORD_SIZE),
    .RD_LAT   (RD_LAT)
  ) u_rd_pipe (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (rd_ok),
    .in_err   (accept && bad),
    .in_data  (rd_word),
    .out_valid(VALID),
    .out_err  (ERR),
    .out_data (DATA_OUT)
  );

  assign READY = ready_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl (DEPTH=16, RD_LAT=3, non-zero base).
module tb_dmem_ctrl;

  localparam int unsigned LAT  = 3;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        CLK;
  logic        RST;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [3:0]  BYTE_EN;
  logic        WR_EN;
  logic        RD_EN;
  logic        READY;
  logic [31:0] DATA_OUT;
  logic        VALID;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(
    .WORD_SIZE   (32),
    .DEPTH       (16),
    .RD_LAT      (LAT),
    .BASE_ADDR   (BASE),
    .CLEAR_ON_RST(1'b1),
    .FILENAME    ("")
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ADDR    (ADDR),
    .DATA_IN (DATA_IN),
    .BYTE_EN (BYTE_EN),
    .WR_EN   (WR_EN),
    .RD_EN   (RD_EN),
    .READY   (READY),
    .DATA_OUT(DATA_OUT),
    .VALID   (VALID),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [31:0] w(input int unsigned i);
    return BASE + 32'(4 * i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    WR_EN   = wr;
    RD_EN   = rd;
    ADDR    = a;
    DATA_IN = d;
    BYTE_EN = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0);
  endtask

  // Call just after RST deassertion; a misaligned read is held to prove it is ignored.
  task automatic wait_ready(input string tag);
    int n;
    logic seen_bad;
    n = 0;
    seen_bad = 1'b0;
    drive(1'b0, 1'b1, BASE + 32'd2, 32'h0000_0000, 4'h0);
    repeat (2) begin
      tick();
      seen_bad = seen_bad | VALID | ERR | READY;
    end
    while (!READY && n < 100) begin
      tick();
      n++;
      seen_bad = seen_bad | VALID | ERR;
    end
    idle();
    chk({tag, "_ready_latency"}, 32'(n), 32'd16);
    chk({tag, "_quiet_during_clear"}, {31'd0, seen_bad}, 32'd0);
  endtask

  initial begin
    //          wr    rd    addr           data           be     ev    ee    ed
    tbl[0]  = '{1'b0, 1'b1, w(5),          32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, w(2),          32'h11223344,  4'hF, 1'b0, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b1, 1'b0, w(2),          32'hDEADBEEF,  4'h5, 1'b0, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 1'b1, w(2),          32'h0,         4'h0, 1'b1, 1'b0, 32'h11AD33EF};
    tbl[4]  = '{1'b0, 1'b1, BASE + 32'd2,  32'h0,         4'h0, 1'b0, 1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 1'b0, BASE + 32'd2,  32'hFFFFFFFF,  4'hF, 1'b0, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b0, 1'b1, BASE + 32'd64, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0000_0000};
    tbl[7]  = '{1'b1, 1'b0, BASE + 32'd64, 32'hFFFFFFFF,  4'hF, 1'b0, 1'b1, 32'h0000_0000};
    tbl[8]  = '{1'b1, 1'b1, w(2),          32'hFFFFFFFF,  4'hF, 1'b0, 1'b1, 32'h0000_0000};
    tbl[9]  = '{1'b0, 1'b1, BASE - 32'd4,  32'h0,         4'h0, 1'b0, 1'b1, 32'h0000_0000};
    tbl[10] = '{1'b0, 1'b1, w(2),          32'h0,         4'h0, 1'b1, 1'b0, 32'h11AD33EF};
    tbl[11] = '{1'b1, 1'b0, w(7),          32'h12345678,  4'h0, 1'b0, 1'b0, 32'h11AD33EF};
    tbl[12] = '{1'b0, 1'b1, w(7),          32'h0,         4'h0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[13] = '{1'b1, 1'b0, w(15),         32'hCAFEF00D,  4'hC, 1'b0, 1'b0, 32'h0000_0000};
    tbl[14] = '{1'b0, 1'b1, w(15),         32'h0,         4'h0, 1'b1, 1'b0, 32'hCAFE0000};

    RST = 1'b1;
    idle();
    repeat (2) tick();
    chk("rst_ready", {31'd0, READY}, 32'd0);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_err",   {31'd0, ERR},   32'd0);
    chk("rst_data",  DATA_OUT,       32'h0000_0000);
    RST = 1'b0;
    wait_ready("init");

    // Each vector: one request, then sample the response slot LAT edges after acceptance.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].be);
      tick();
      idle();
      repeat (LAT - 1) tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, VALID}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_err", i),   {31'd0, ERR},   {31'd0, tbl[i].ee});
      chk($sformatf("vec%0d_data", i),  DATA_OUT,       tbl[i].ed);
    end

    // Back-to-back writes, then reads of words 0,1,2 starting the cycle after writing word 0.
    drive(1'b1, 1'b0, w(1), 32'h1B1B1B1B, 4'hF); tick();
    drive(1'b1, 1'b0, w(2), 32'h2C2C2C2C, 4'hF); tick();
    drive(1'b1, 1'b0, w(0), 32'h0A0A0A0A, 4'hF); tick();
    drive(1'b0, 1'b1, w(0), 32'h0, 4'h0); tick();
    drive(1'b0, 1'b1, w(1), 32'h0, 4'h0); tick();
    chk("b2b_early_valid", {31'd0, VALID}, 32'd0);
    drive(1'b0, 1'b1, w(2), 32'h0, 4'h0); tick();
    chk("b2b_v0", {31'd0, VALID}, 32'd1);
    chk("b2b_d0", DATA_OUT, 32'h0A0A0A0A);
    idle(); tick();
    chk("b2b_v1", {31'd0, VALID}, 32'd1);
    chk("b2b_d1", DATA_OUT, 32'h1B1B1B1B);
    tick();
    chk("b2b_v2", {31'd0, VALID}, 32'd1);
    chk("b2b_d2", DATA_OUT, 32'h2C2C2C2C);
    tick();
    chk("b2b_end_valid", {31'd0, VALID}, 32'd0);
    chk("b2b_hold", DATA_OUT, 32'h2C2C2C2C);

    // Reset with two reads in flight: nothing may emerge, then the fill runs again.
    drive(1'b0, 1'b1, w(0), 32'h0, 4'h0); tick();
    drive(1'b0, 1'b1, w(1), 32'h0, 4'h0); tick();
    idle();
    RST = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, READY}, 32'd0);
    chk("mid_rst_valid", {31'd0, VALID}, 32'd0);
    chk("mid_rst_data",  DATA_OUT,       32'h0000_0000);
    repeat (3) begin
      tick();
      chk("mid_rst_flush", {31'd0, VALID | ERR}, 32'd0);
    end
    RST = 1'b0;
    wait_ready("rerst");
    drive(1'b0, 1'b1, w(1), 32'h0, 4'h0);
    tick();
    idle();
    repeat (LAT - 1) tick();
    chk("rerst_read_valid", {31'd0, VALID}, 32'd1);
    chk("rerst_read_data",  DATA_OUT,       32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
